// File: rtl/fifo_rr_arbiter.sv
// fifo_rr_arbiter: drains NUM_Q upstream FIFOs round-robin and routes each word
// to the downstream FIFO selected by the word's top SEL_WIDTH bits.
module fifo_rr_arbiter #(
    parameter int DATA_WIDTH = 6,
    parameter int SEL_WIDTH  = 2,
    localparam int NUM_Q     = 2 ** SEL_WIDTH
) (
    input  logic                          clk,
    input  logic                          reset_L,
    input  logic [NUM_Q-1:0]              in_empty,
    input  logic [NUM_Q*DATA_WIDTH-1:0]   in_data,
    output logic [NUM_Q-1:0]              in_pop,
    input  logic [NUM_Q-1:0]              out_pause,
    output logic [NUM_Q-1:0]              out_push,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [SEL_WIDTH-1:0]          grant_id,
    output logic                          active,
    output logic [15:0]                   fwd_count
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [NUM_Q-1:0]      in_pop_q, in_pop_d;
    logic [SEL_WIDTH-1:0]  ptr_q, ptr_d;
    logic [SEL_WIDTH-1:0]  grant_id_q, grant_id_d;
    logic                  s1_valid_q, s1_valid_d;
    logic [SEL_WIDTH-1:0]  s1_idx_q, s1_idx_d;
    logic [NUM_Q-1:0]      out_push_q, out_push_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [15:0]           fwd_count_q, fwd_count_d;
    logic [0:0]            state_q, state_d;
    logic [NUM_Q-1:0]      eligible;
    logic                  gnt_found, grant;
    logic [SEL_WIDTH-1:0]  gnt_idx;
    logic [DATA_WIDTH-1:0] word;

    always_comb begin
        // masking last cycle's grant hides the upstream empty flag's one-cycle lag
        eligible = ~in_empty & ~in_pop_q;
        gnt_found = 1'b0;
        gnt_idx = ptr_q;
        for (int k = NUM_Q - 1; k >= 0; k--) begin
            if (eligible[ptr_q + SEL_WIDTH'(k)]) begin
                gnt_found = 1'b1;
                gnt_idx = ptr_q + SEL_WIDTH'(k);
            end
        end
        grant = gnt_found && !(|out_pause);
        in_pop_d = grant ? NUM_Q'(1) << gnt_idx : '0;
        grant_id_d = grant ? gnt_idx : grant_id_q;
        ptr_d = grant ? gnt_idx + 1'b1 : ptr_q;
        s1_valid_d = |in_pop_q;
        s1_idx_d = grant_id_q;
        word = in_data[s1_idx_q*DATA_WIDTH +: DATA_WIDTH];
        out_push_d = s1_valid_q ? NUM_Q'(1) << word[DATA_WIDTH-1 -: SEL_WIDTH] : '0;
        out_data_d = s1_valid_q ? word : out_data_q;
        fwd_count_d = fwd_count_q + {15'd0, s1_valid_q};
        state_d = (grant || s1_valid_d || s1_valid_q) ? BUSY : IDLE;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            in_pop_q    <= '0;
            ptr_q       <= '0;
            grant_id_q  <= '0;
            s1_valid_q  <= 1'b0;
            s1_idx_q    <= '0;
            out_push_q  <= '0;
            out_data_q  <= '0;
            fwd_count_q <= '0;
            state_q     <= IDLE;
        end else begin
            in_pop_q    <= in_pop_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            s1_valid_q  <= s1_valid_d;
            s1_idx_q    <= s1_idx_d;
            out_push_q  <= out_push_d;
            out_data_q  <= out_data_d;
            fwd_count_q <= fwd_count_d;
            state_q     <= state_d;
        end
    end

    assign in_pop    = in_pop_q;
    assign out_push  = out_push_q;
    assign out_data  = out_data_q;
    assign grant_id  = grant_id_q;
    assign active    = (state_q == BUSY);
    assign fwd_count = fwd_count_q;
endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb_fifo_rr_arbiter: upstream FIFOs emulated as queues; a round-robin reference
// model predicts grants and a scoreboard checks every forwarded word and its timing.
module tb_fifo_rr_arbiter;
    localparam int NQ = 4;
    localparam int DW = 6;

    typedef struct {
        int         due;
        logic [3:0] push;
        logic [5:0] data;
    } exp_t;

    logic           clk = 1'b0;
    logic           reset_L = 1'b0;
    logic [NQ-1:0]  in_empty, in_pop, out_pause, out_push;
    logic [NQ*DW-1:0] in_data;
    logic [DW-1:0]  out_data;
    logic [1:0]     grant_id;
    logic           active;
    logic [15:0]    fwd_count;

    int checks = 0, errors = 0, cyc = 0;
    logic [5:0] fq[NQ][$];
    logic [5:0] dreg[NQ];
    exp_t exp_q[$];
    int m_last = NQ - 1, m_prev = -1, m_gid = 0, m_fwd = 0, m_gnow = -1;
    logic [NQ-1:0] pend = '0, refill = '0;

    fifo_rr_arbiter dut (
        .clk(clk), .reset_L(reset_L), .in_empty(in_empty), .in_data(in_data),
        .in_pop(in_pop), .out_pause(out_pause), .out_push(out_push),
        .out_data(out_data), .grant_id(grant_id), .active(active),
        .fwd_count(fwd_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
        end
    endtask

    function automatic int predict();
        int i;
        if (|out_pause) return -1;
        for (int k = 1; k <= NQ; k++) begin
            i = (m_last + k) % NQ;
            if (!in_empty[i] && i != m_prev) return i;
        end
        return -1;
    endfunction

    function automatic logic any_queued();
        for (int i = 0; i < NQ; i++) if (fq[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive();
        for (int i = 0; i < NQ; i++) begin
            in_empty[i] = (fq[i].size() == 0);
            in_data[i*DW +: DW] = dreg[i];
        end
    endtask

    task automatic step();
        int eg;
        eg = predict();
        @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) begin
            if (pend[i]) begin
                chk("pop_nonempty", 32'(fq[i].size() != 0), 32'd1);
                if (fq[i].size() != 0) begin
                    dreg[i] = fq[i].pop_front();
                    exp_q.push_back('{cyc + 1, 4'(4'd1 << dreg[i][5:4]), dreg[i]});
                end
            end
        end
        chk("in_pop", 32'(in_pop), (eg >= 0) ? 32'(4'd1 << eg) : 32'd0);
        if (eg >= 0) begin
            m_last = eg;
            m_gid = eg;
        end
        m_prev = eg;
        m_gnow = eg;
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        pend = in_pop;
        for (int i = 0; i < NQ; i++)
            if (refill[i] && fq[i].size() < 4 && $urandom_range(0, 3) != 0)
                fq[i].push_back(6'($urandom_range(0, 63)));
        drive();
    endtask

    task automatic fill_all();
        for (int i = 0; i < NQ; i++)
            repeat (3) fq[i].push_back(6'($urandom_range(0, 63)));
        drive();
    endtask

    task automatic drain();
        refill = '0;
        for (int n = 0; n < 100 && any_queued(); n++) step();
        chk("drain_done", 32'(any_queued()), 32'd0);
        repeat (4) step();
    endtask

    // monitor: compares every cycle against the scoreboard head
    always @(negedge clk) begin
        if (!reset_L) begin
            exp_q.delete();
            m_fwd = 0;
        end else begin
            chk("active", 32'(active), 32'((m_gnow >= 0) || (exp_q.size() > 0)));
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                chk("push_missing", 32'(cyc), 32'(exp_q[0].due));
                void'(exp_q.pop_front());
            end
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                chk("out_push", 32'(out_push), 32'(exp_q[0].push));
                chk("out_data", 32'(out_data), 32'(exp_q[0].data));
                m_fwd++;
                void'(exp_q.pop_front());
            end else begin
                chk("out_push_idle", 32'(out_push), 32'd0);
            end
            chk("fwd_count", 32'(fwd_count), 32'(m_fwd % 65536));
        end
    end

    initial begin
        in_empty = '1;
        in_data = '0;
        out_pause = '0;
        for (int i = 0; i < NQ; i++) dreg[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_pop", 32'(in_pop), 32'd0);
        chk("rst_out_push", 32'(out_push), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_grant_id", 32'(grant_id), 32'd0);
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_fwd_count", 32'(fwd_count), 32'd0);
        @(posedge clk);
        #1;
        reset_L = 1'b1;

        fq[2].push_back(6'b01_0101);
        drive();
        repeat (5) step();
        chk("single_fwd_count", 32'(fwd_count), 32'd1);
        chk("single_grant_id", 32'(grant_id), 32'd2);

        refill = '1;
        fill_all();
        repeat (12) step();
        out_pause = 4'b1000;
        repeat (3) step();
        out_pause = '0;
        repeat (4) step();
        drain();

        fq[1].push_back(6'($urandom_range(0, 63)));
        fq[1].push_back(6'($urandom_range(0, 63)));
        drive();
        repeat (6) step();

        refill = '1;
        fill_all();
        repeat (6) step();
        #2;
        reset_L = 1'b0;
        m_gnow = -1;
        #1;
        chk("arst_in_pop", 32'(in_pop), 32'd0);
        chk("arst_out_push", 32'(out_push), 32'd0);
        chk("arst_fwd_count", 32'(fwd_count), 32'd0);
        chk("arst_active", 32'(active), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < NQ; i++) fq[i].delete();
        pend = '0;
        refill = '0;
        m_last = NQ - 1;
        m_prev = -1;
        m_gid = 0;
        fq[0].push_back(6'b11_0000);
        fq[3].push_back(6'b00_1111);
        drive();
        reset_L = 1'b1;
        repeat (6) step();

        refill = '1;
        repeat (300) begin
            out_pause = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            step();
        end
        out_pause = '0;
        drain();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_rr_arbiter.md
Name: fifo_rr_arbiter

Overview:
- Downstream stage of the 6-bit FIFO bank.
- Drains NUM_Q upstream FIFOs with round-robin arbitration and routes each word to one of NUM_Q downstream FIFOs.
- The destination index is taken from the word's top SEL_WIDTH bits.
- Honours the downstream FIFOs' Pausa (almost-full) back-pressure and never pops an upstream FIFO flagged empty.

Parameters:
DATA_WIDTH, 6, word width; matches the FIFO data width.
SEL_WIDTH, 2, destination/queue index width; NUM_Q = 2**SEL_WIDTH = 4.

Ports:
clk  input  1  clock, rising edge.
reset_L  input  1  asynchronous active-low reset; clears all state immediately on assertion.
in_empty  input  NUM_Q  Fifo_Empty of upstream FIFO i at bit i.
in_data  input  NUM_Q*DATA_WIDTH  Fifo_Data_out of upstream FIFO i at [i*DATA_WIDTH +: DATA_WIDTH].
in_pop  output  NUM_Q  pop strobe to upstream FIFO i; at most one bit high.
out_pause  input  NUM_Q  Pausa of downstream FIFO j at bit j.
out_push  output  NUM_Q  push strobe to downstream FIFO j; at most one bit high.
out_data  output  DATA_WIDTH  word presented with out_push.
grant_id  output  SEL_WIDTH  index of the most recent grant.
active  output  1  high while any pop or forward is in flight.
fwd_count  output  16  total words forwarded; wraps at 65535 -> 0.

Behaviour:
- Reset (asynchronous, active-low): in_pop=0, out_push=0, out_data=0, grant_id=0, active=0, fwd_count=0, rr pointer=0, both pipeline stages invalid. Words in flight at reset are discarded.
- Pipeline, three stages, one word per cycle throughput:
  - Cycle N (grant): in_pop[g] high for exactly one cycle.
  - Cycle N+1 (capture): in_data[g] is valid. The block registers the word and g into stage-2.
  - Cycle N+2 (forward): out_push[d] high for one cycle and out_data = word, where d = word[DATA_WIDTH-1 -: SEL_WIDTH]. fwd_count increments on the same edge.
  - Pop-to-push latency is 2 cycles.
- Grant eligibility: queue i is eligible iff in_empty[i]==0 and i was not granted in the previous cycle. The mask covers the one-cycle lag of the registered empty flag, so back-to-back pops of the same queue are impossible.
- Round-robin order: search starts at (grant_id+1) mod NUM_Q, with grant_id=NUM_Q-1 implied after reset so that queue 0 has first priority. The first eligible queue wins, and grant_id updates on the grant edge. Wrap from NUM_Q-1 to 0.
- Stall: no new grant is issued in any cycle where any out_pause bit is high; the destination is unknown before the pop.
  - Words already in stages 1-2 always complete. Downstream FIFOs must keep at least 2 free entries after raising Pausa.
  - Granting resumes the cycle after out_pause returns to all-zero, from the saved rr pointer.
- Idle: if no queue is eligible and no stall is in effect, in_pop=0 and grant_id holds.
- State machine (registered):
  - IDLE: no stage valid. Moves to BUSY on a grant.
  - BUSY: at least one stage valid or a grant this cycle. Returns to IDLE when both stages are empty and no grant is issued.
  - active = (state==BUSY).
- Simultaneous events: a grant, a capture and a forward may all occur in the same cycle. A pause arriving in the same cycle as a forward does not cancel the forward.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Reset, then only queue 2 non-empty holding word 6'b01_0101. Required: in_pop=4'b0100 on cycle 1, out_push=4'b0010 and out_data=6'h15 on cycle 3, fwd_count=1, grant_id=2.
- All four queues non-empty continuously, out_pause=0. Required: grants in order 0,1,2,3,0,...; one forward per cycle after a 2-cycle fill; fwd_count=8 after 8 forwards.
- Only queue 1 non-empty, in_empty held low for 4 cycles. Required: in_pop[1] pulses on alternating cycles only (1,0,1,0), never two consecutive cycles.
- out_pause=4'b1000 raised while a grant is 1 cycle old. Required: no in_pop while paused; the 2 in-flight words still push; after out_pause=0, granting resumes at the next rr queue.
- reset_L dropped asynchronously mid-cycle with both stages valid. Required: out_push, in_pop and fwd_count clear immediately; no forward after release; first grant goes to queue 0.
- Word 6'b11_0000 from queue 0 followed by 6'b00_1111 from queue 3. Required: out_push=4'b1000, then 4'b0001 on consecutive cycles with the matching out_data.
